// File: rtl/arm_move_sequencer.sv
// Point-to-point joint move sequencer: one command at a time ramps the selected
// joint one step per prescaler tick to its target, dwells, then reports done.
module arm_move_sequencer #(
    parameter int NJ        = 4,
    parameter int PW        = 8,
    parameter int TICK_DIV  = 50,
    parameter int SEC_TICKS = 60,
    parameter int HOME      = 128,
    parameter int POS_MIN   = 16,
    parameter int POS_MAX   = 240
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_joint,
    input  logic [PW-1:0]   cmd_target,
    input  logic [7:0]      cmd_dwell,
    input  logic            abort,
    output logic [NJ*PW-1:0] pos_flat,
    output logic            busy,
    output logic [1:0]      active_joint,
    output logic            done,
    output logic            aborted,
    output logic            tick
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MOVE  = 2'd1;
    localparam logic [1:0] S_DWELL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam int UNIT_W  = $clog2(SEC_TICKS + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [UNIT_W-1:0]  UNIT_LAST  = UNIT_W'(SEC_TICKS - 1);
    localparam logic [PW-1:0]      HOME_P     = PW'(HOME);
    localparam logic [PW-1:0]      MIN_P      = PW'(POS_MIN);
    localparam logic [PW-1:0]      MAX_P      = PW'(POS_MAX);
    localparam logic [2:0]         NJ_P       = 3'(NJ);

    logic [1:0]         state_reg, state_next;
    logic [PRESC_W-1:0] presc_reg;
    logic [1:0]         joint_reg;
    logic [PW-1:0]      target_reg;
    logic [7:0]         dwell_reg;
    logic [7:0]         rem_reg;
    logic [UNIT_W-1:0]  unit_reg;
    logic               aborted_reg;

    logic [PW-1:0] pos_vec [NJ];
    logic [PW-1:0] cur_pos;
    logic [PW-1:0] clamp_target;
    logic          tick_w;
    logic          accept;
    logic          bad_joint;
    logic          at_target;
    logic          abort_hit;

    assign tick_w    = (state_reg != S_IDLE) && (presc_reg == PRESC_LAST);
    assign accept    = (state_reg == S_IDLE) && cmd_valid;
    assign bad_joint = ({1'b0, cmd_joint} >= NJ_P);
    assign at_target = (cur_pos == target_reg);
    assign abort_hit = abort && ((state_reg == S_MOVE) || (state_reg == S_DWELL));

    assign clamp_target = (cmd_target < MIN_P) ? MIN_P :
                          (cmd_target > MAX_P) ? MAX_P : cmd_target;

    always_comb begin
        cur_pos = HOME_P;
        for (int j = 0; j < NJ; j++) begin
            if (joint_reg == 2'(j)) begin
                cur_pos = pos_vec[j];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_next = bad_joint ? S_DONE : S_MOVE;
                end
            end
            S_MOVE: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (tick_w && at_target) begin
                    state_next = S_DWELL;
                end
            end
            S_DWELL: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (tick_w && (rem_reg == 8'd0)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            presc_reg   <= '0;
            joint_reg   <= 2'd0;
            target_reg  <= HOME_P;
            dwell_reg   <= 8'd0;
            rem_reg     <= 8'd0;
            unit_reg    <= '0;
            aborted_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            aborted_reg <= abort_hit;

            // Prescaler is parked at zero in IDLE so the first tick lands TICK_DIV cycles after accept.
            if ((state_reg == S_IDLE) || (presc_reg == PRESC_LAST)) begin
                presc_reg <= '0;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end

            if (accept) begin
                joint_reg  <= cmd_joint;
                dwell_reg  <= cmd_dwell;
                target_reg <= clamp_target;
            end

            if ((state_reg == S_MOVE) && tick_w && at_target && !abort) begin
                rem_reg  <= dwell_reg;
                unit_reg <= '0;
            end

            if ((state_reg == S_DWELL) && tick_w && !abort && (rem_reg != 8'd0)) begin
                if (unit_reg == UNIT_LAST) begin
                    unit_reg <= '0;
                    rem_reg  <= rem_reg - 8'd1;
                end else begin
                    unit_reg <= unit_reg + 1'b1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NJ; gi++) begin : g_joint
            logic [PW-1:0] pos_reg;
            logic          step_en;

            // Abort takes priority over a coincident tick, so the position freezes.
            assign step_en = (state_reg == S_MOVE) && tick_w && !abort &&
                             (joint_reg == 2'(gi)) && (pos_reg != target_reg);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pos_reg <= HOME_P;
                end else if (step_en) begin
                    if (pos_reg < target_reg) begin
                        pos_reg <= pos_reg + 1'b1;
                    end else begin
                        pos_reg <= pos_reg - 1'b1;
                    end
                end
            end

            assign pos_vec[gi]            = pos_reg;
            assign pos_flat[gi*PW +: PW]  = pos_reg;
        end
    endgenerate

    assign cmd_ready    = (state_reg == S_IDLE);
    assign busy         = (state_reg != S_IDLE);
    assign done         = (state_reg == S_DONE);
    assign aborted      = aborted_reg;
    assign tick         = tick_w;
    assign active_joint = joint_reg;

endmodule

// File: doc/arm_move_sequencer.md
Name: arm_move_sequencer

Overview: Sequences point-to-point moves of the robotic arm joints on a common step timebase. An internal prescaler generates a step tick every TICK_DIV clocks, and a dwell counter counts ticks in units of SEC_TICKS. One command is executed at a time: the selected joint ramps one position step per tick to its target, holds for a dwell time, then signals completion. The block sits between the command source and the per-joint PWM generators, which consume pos_flat.

Parameters:
NJ, 4, number of joints (max 4; cmd_joint is 2 bits)
PW, 8, position width per joint
TICK_DIV, 50, clk cycles per step tick (>=2)
SEC_TICKS, 60, ticks per dwell unit (>=1)
HOME, 128, reset position of every joint
POS_MIN, 16, lowest legal position
POS_MAX, 240, highest legal position

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
cmd_joint  in  2  joint index, 0..NJ-1
cmd_target  in  PW  target position
cmd_dwell  in  8  dwell time in SEC_TICKS units
abort  in  1  cancel the active command
pos_flat  out  NJ*PW  current joint positions, joint j at bits [j*PW +: PW]
busy  out  1  high in MOVE, DWELL and DONE
active_joint  out  2  joint of the current or last command
done  out  1  one-cycle completion pulse
aborted  out  1  one-cycle abort pulse
tick  out  1  prescaler tick (debug/observe)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all positions = HOME; prescaler=0; dwell counters=0; cmd_ready=1; busy, done, aborted, tick = 0; active_joint=0.
- FSM states: IDLE, MOVE, DWELL, DONE. cmd_ready = (state==IDLE). busy = !IDLE. All outputs are registered or a direct decode of state.
- Accept (IDLE and cmd_valid): latch joint and dwell. Latch target clamped to [POS_MIN,POS_MAX]. Clear the prescaler to 0. Go to MOVE. If cmd_joint >= NJ, do not move any joint: go straight to DONE.
- Prescaler: runs only outside IDLE. Counts 0..TICK_DIV-1 and wraps. tick=1 for the single cycle where prescaler==TICK_DIV-1, so the first tick falls TICK_DIV cycles after accept.
- MOVE, on each tick: if pos==target, go to DWELL and load rem=dwell, unit=0. Otherwise pos moves ±1 toward target.
  - A move of distance d takes d+1 ticks to reach DWELL.
  - Position never leaves [POS_MIN,POS_MAX]. Other joints hold their values.
- DWELL, on each tick: if rem==0, go to DONE. Otherwise unit increments; when unit reaches SEC_TICKS-1 it wraps to 0 and rem decrements. Total DWELL time is dwell*SEC_TICKS+1 ticks.
- DONE: lasts 1 cycle with done=1, then IDLE. A new command is accepted no earlier than the cycle after DONE.
- abort while in MOVE or DWELL: at the next edge go to IDLE with aborted=1 for 1 cycle and done=0. Positions freeze at their current values. abort in IDLE or DONE is ignored, and DONE still completes. If abort and tick coincide, abort wins and no step is applied.
- cmd_valid while busy: ignored (not queued). cmd_* only needs to be stable in the accept cycle.
- Reset mid-operation: immediate return to the reset values, positions = HOME.

Test Plan:
1. Reset, then idle for 10 cycles -> pos_flat = {4{8'd128}}, cmd_ready=1, busy=0, no tick.
2. Joint 1, target 130, dwell 0 (TICK_DIV=50) -> pos1 = 129 at accept+50 and 130 at accept+100; DWELL entered at accept+150; DONE at accept+200; done high exactly one cycle; the other joints stay at 128.
3. Joint 0, target 126, dwell 1 (SEC_TICKS=60) -> pos0 steps down to 126 in 2 ticks; DWELL lasts 61 ticks; done at accept+(3+61)*50 edges; cmd_ready returns the cycle after done.
4. Joint 2, target 250 -> clamped to 240; pos2 saturates at 240 and never exceeds it; done is issued normally.
5. Abort issued on the same cycle as the tick after pos3 reaches 131 during a move 128->140 -> pos3 holds at 131; aborted pulses once; done stays 0; IDLE the next cycle; a fresh command is accepted afterwards.
6. rst_n dropped during DWELL, and cmd_valid held during MOVE -> asynchronous return to HOME and IDLE; the command offered during MOVE is never executed and cmd_ready stays 0 until IDLE.
